// File: rtl/reg_bank_8x16_wr.sv
// reg_bank_8x16_wr: 8x16 register bank with decoded write, two combinational read ports and optional write bypass.
module reg_bank_8x16_wr #(
  parameter int WIDTH = 16,
  parameter bit BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [2:0]       rd_addr_a,
  input  logic [2:0]       rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic [7:0]       wr_onehot,
  output logic [15:0]      wr_count
);
  logic [WIDTH-1:0] regs [8];
  logic [7:0] dec;
  // gating by wr_en keeps an unknown wr_addr from reaching any enable while idle
  assign dec = wr_en ? 8'(1) << wr_addr : 8'h00;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      wr_onehot <= 8'h00;
      wr_count <= 16'h0000;
    end else begin
      for (int i = 1; i < 8; i++) if (dec[i]) regs[i] <= wr_data;
      wr_onehot <= dec;
      if (wr_en && wr_addr != 3'd0) wr_count <= wr_count + 16'd1;
    end
  assign rd_data_a = rd_addr_a == 3'd0 ? '0 : (BYPASS && dec[rd_addr_a]) ? wr_data : regs[rd_addr_a];
  assign rd_data_b = rd_addr_b == 3'd0 ? '0 : (BYPASS && dec[rd_addr_b]) ? wr_data : regs[rd_addr_b];
endmodule

// File: tb/tb_reg_bank_8x16_wr.sv
// tb_reg_bank_8x16_wr: scoreboard bench comparing bypass and non-bypass banks against an array model.
module tb_reg_bank_8x16_wr;
  logic clk = 1'b0;
  logic rst;
  logic wr_en;
  logic [2:0] wr_addr, rd_addr_a, rd_addr_b;
  logic [15:0] wr_data;
  logic [15:0] a1, b1, a0, b0, cnt1, cnt0;
  logic [7:0] oh1, oh0;
  int nchk = 0;
  int nerr = 0;
  typedef struct {
    logic [15:0] a1, b1, a0, b0, cnt;
    logic [7:0] oh;
  } exp_t;
  exp_t q[$];
  logic [15:0] m [8];
  logic [15:0] cnt_m;
  logic [7:0] oh_m;

  always #5 clk = ~clk;

  reg_bank_8x16_wr #(.WIDTH(16), .BYPASS(1'b1)) u1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(a1), .rd_data_b(b1),
    .wr_onehot(oh1), .wr_count(cnt1));
  reg_bank_8x16_wr #(.WIDTH(16), .BYPASS(1'b0)) u0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(a0), .rd_data_b(b0),
    .wr_onehot(oh0), .wr_count(cnt0));

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] rdm(input logic [2:0] a, input bit byp);
    if (a == 3'd0) return 16'h0000;
    if (byp && wr_en && wr_addr == a) return wr_data;
    return m[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 8; i++) m[i] = 16'h0000;
    cnt_m = 16'h0000;
    oh_m = 8'h00;
  endtask

  // called just after a rising edge: drive, predict pre-edge view, then retire the edge in the model
  task automatic cyc(input logic r, input logic we, input logic [2:0] wa, input logic [15:0] wd,
                     input logic [2:0] ra, input logic [2:0] rb, input bit pulse);
    exp_t e;
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd; rd_addr_a = ra; rd_addr_b = rb;
    if (r) clear_model();
    e.a1 = rdm(ra, 1'b1); e.b1 = rdm(rb, 1'b1);
    e.a0 = rdm(ra, 1'b0); e.b0 = rdm(rb, 1'b0);
    e.oh = oh_m; e.cnt = cnt_m;
    q.push_back(e);
    if (pulse) begin
      @(negedge clk);
      #1 rst = 1'b0;
    end
    @(posedge clk);
    if (rst) clear_model();
    else begin
      oh_m = we ? 8'(1) << wa : 8'h00;
      if (we && wa != 3'd0) begin
        m[wa] = wd;
        cnt_m = cnt_m + 16'd1;
      end
    end
    #1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("rd_a_bypass", a1, e.a1);
        chk("rd_b_bypass", b1, e.b1);
        chk("rd_a_nobypass", a0, e.a0);
        chk("rd_b_nobypass", b0, e.b0);
        chk("wr_onehot", {8'h00, oh1}, {8'h00, e.oh});
        chk("wr_count", cnt1, e.cnt);
        chk("wr_count_nobypass", cnt0, e.cnt);
        chk("wr_onehot_nobypass", {8'h00, oh0}, {8'h00, e.oh});
      end
    end
  end

  initial begin
    logic [2:0] wa, ra, rb;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 1; i < 8; i++) cyc(1'b0, 1'b1, 3'(i), 16'(i * 16'h1111), 3'(i), 3'(i - 1), 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 3'd0, 16'h0, 3'(i), 3'(7 - i), 1'b0);
    cyc(1'b0, 1'b1, 3'd0, 16'hBEEF, 3'd0, 3'd0, 1'b0);
    cyc(1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd1, 1'b0);
    cyc(1'b0, 1'b1, 3'd5, 16'h1234, 3'd1, 3'd2, 1'b0);
    cyc(1'b0, 1'b1, 3'd5, 16'hABCD, 3'd5, 3'd5, 1'b0);
    cyc(1'b0, 1'b0, 3'd5, 16'h0, 3'd5, 3'd5, 1'b0);
    for (int i = 0; i < 10; i++)
      cyc(1'b0, 1'b0, 3'($urandom_range(0, 7)), 16'($urandom), 3'(i % 8), 3'((i + 3) % 8), 1'b0);
    cyc(1'b1, 1'b0, 3'd0, 16'h0, 3'd2, 3'd7, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 3'd0, 16'h0, 3'(i), 3'(i), 1'b0);
    for (int i = 0; i < 400; i++) begin
      wa = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 2) == 0) ? wa : 3'($urandom_range(0, 7));
      rb = ($urandom_range(0, 2) == 0) ? wa : 3'($urandom_range(0, 7));
      cyc(1'b0, 1'($urandom), wa, 16'($urandom), ra, rb, 1'b0);
    end
    cyc(1'b1, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0);
    for (int i = 0; i < 65535; i++)
      cyc(1'b0, 1'b1, 3'($urandom_range(1, 7)), 16'($urandom), 3'($urandom_range(0, 7)), 3'd3, 1'b0);
    cyc(1'b0, 1'b1, 3'd3, 16'h5A5A, 3'd3, 3'd3, 1'b0);
    cyc(1'b0, 1'b0, 3'd0, 16'h0, 3'd3, 3'd1, 1'b0);
    cyc(1'b1, 1'b1, 3'd3, 16'hC3C3, 3'd3, 3'd3, 1'b0);
    cyc(1'b0, 1'b0, 3'd0, 16'h0, 3'd3, 3'd3, 1'b0);
    cyc(1'b0, 1'b1, 3'd3, 16'h7777, 3'd3, 3'd2, 1'b0);
    cyc(1'b0, 1'b0, 3'd0, 16'h0, 3'd3, 3'd0, 1'b0);
    @(negedge clk);
    #1;
    nchk++;
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
